fpdivsqrt_seq: RTL and testbench
================================

// Module: fpdivsqrt_seq
// PURPOSE
//  Sequencer/result stage for the double-precision divide/square-root unit; sits directly downstream of the combinational exception classifier.
//  Accepts an operation, consumes the classifier's Ztype/Invalid/Denorm, and resolves special results locally in 2 cycles.
//  Otherwise launches the iterative datapath and collects its result after a fixed latency.
//  Presents a registered result plus IEEE flags with a one-cycle done pulse.
// PARAMETERS
//  LAT  default 10  datapath latency in cycles from dp_start to valid dp_result/dp_flags; LAT>=1
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  start         in   1   request; accepted only when busy=0
//  op_type       in   1   0 = divide A/B, 1 = sqrt(A)
//  A             in   64  operand 1 (IEEE double)
//  B             in   64  operand 2 (ignored for sqrt)
//  Ztype         in   3   classifier result type for the current A,B,op_type
//                         000 normal, 001 qNaN, 010 Inf, 011 zero, 110 div-by-zero
//  Invalid       in   1   classifier invalid-operation indication
//  Denorm        in   1   classifier denormal-operand indication
//  dp_start      out  1   one-cycle pulse launching the datapath on the captured operands
//  dp_result     in   64  datapath result, sampled when the latency counter expires
//  dp_flags      in   5   datapath flags {NV,DZ,OF,UF,NX}, sampled with dp_result
//  busy          out  1   high from accept until and including the done cycle
//  done          out  1   one-cycle pulse; result/flags valid from this cycle
//  result        out  64  final result; held until the next accepted start
//  flags         out  5   {NV,DZ,OF,UF,NX} for the completed operation; held like result
//  denorm_flag   out  1   Denorm captured at accept; held like result
//  clr_flags     in   1   clears sticky flags (macro only)
//  sticky_flags  out  5   accumulated flags (macro only)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, dp_start=0; result=0, flags=0, denorm_flag=0, sticky_flags=0; counter=0.
//  FSM states: IDLE, SPECIAL, RUN, DONE.
//  IDLE, start=1:
//   - Capture A, B, op_type, Ztype, Invalid, Denorm; busy=1 next cycle.
//   - Go to SPECIAL if the operation is special (see decode); else go to RUN.
//  SPECIAL: form the special result and flags -> DONE.
//  RUN:
//   - dp_start=1 on the first RUN cycle only; counter loads LAT-1.
//   - Counter decrements each cycle; at 0, capture dp_result/dp_flags -> DONE.
//  DONE: done=1 for one cycle -> IDLE; busy=0 from the next cycle.
//  Latency (accept edge to done): special 2 cycles; normal LAT+2 cycles.
//  start while busy=1 (including the done cycle) is ignored; no queueing.
//  Special decode on captured values, first match wins:
//   1. Invalid=1 -> 0x7FF8_0000_0000_0000; NV=1.
//   2. A is NaN, or (divide and B is NaN), checked locally (exp all ones, mantissa nonzero) -> 0x7FF8_0000_0000_0000; no NV.
//   3. Ztype[2]=1 -> Inf with sign A[63]^B[63]; DZ=1.
//   4. Ztype=011 -> zero; sign A[63]^B[63] for divide, A[63] for sqrt.
//   5. Ztype=010 -> Inf; sign A[63]^B[63] for divide, + for sqrt.
//   6. Ztype=001 -> 0x7FF8_0000_0000_0000.
//   7. Ztype=000 -> normal path (RUN).
//  Special results have OF=UF=NX=0. Normal-path flags are dp_flags verbatim.
//  Reset asserted in any state: next cycle IDLE with reset values; an in-flight op is abandoned (no done, no dp_start).
// CONFIGURATION
//  FDIV_STICKY_FLAGS_EN defined:
//   - On each done, sticky_flags |= flags of that op.
//   - clr_flags=1 clears sticky_flags to 0.
//   - clr_flags in the same cycle as done: sticky_flags = that op's flags.
//  Not defined: sticky_flags tied to 0; clr_flags ignored; no sticky register.
// TESTING
//  1. 6.0/2.0 (0x4018..., 0x4000...), Ztype=000, dp model returns 0x4008_0000_0000_0000 -> one dp_start; done LAT+2 cycles after accept; result 0x4008_0000_0000_0000; flags 00000.
//  2. 1.0/+0.0, Ztype=110 -> no dp_start; done 2 cycles after accept; result 0x7FF0_0000_0000_0000; flags 01000.
//  3. sqrt(-4.0) (0xC010...), Invalid=1 -> result 0x7FF8_0000_0000_0000; flags 10000; done after 2 cycles.
//  4. -0.0/+Inf, Ztype=011 -> result 0x8000_0000_0000_0000, flags 00000.
//     Repeat as sqrt(-0.0) -> result 0x8000_0000_0000_0000.
//  5. start pulsed on cycles 1-3 of RUN -> ignored; exactly one done.
//     Then reset mid-RUN -> busy=0, result=0 next cycle; no done.
//  6. FDIV_STICKY_FLAGS_EN: run op with NX, then op with DZ -> sticky 01001.
//     clr_flags coincident with a done carrying 00001 -> sticky 00001.
//     Without macro -> sticky_flags=0 throughout.

Source files
------------

// File: rtl/fpdivsqrt_seq.sv
// Sequencer/result stage for the double-precision divide/sqrt unit: resolves special
// operands locally, otherwise runs the iterative datapath. Optional macro: FDIV_STICKY_FLAGS_EN.
module fpdivsqrt_seq #(
  parameter int unsigned LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_type,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  Ztype,
  input  logic        Invalid,
  input  logic        Denorm,
  output logic        dp_start,
  input  logic [63:0] dp_result,
  input  logic [4:0]  dp_flags,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  flags,
  output logic        denorm_flag,
  input  logic        clr_flags,
  output logic [4:0]  sticky_flags
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_SPECIAL, S_RUN, S_DONE} state_t;

  state_t      state_q;
  logic [63:0] a_q, b_q, res_q;
  logic        op_q, inv_q, den_q, busy_q, done_q, dps_q;
  logic [2:0]  z_q;
  logic [4:0]  flg_q;
  logic [CW-1:0] cnt_q;

  logic [63:0] sp_res_d;
  logic [4:0]  sp_flg_d;
  logic        sx_d, special_in_d;

  function automatic logic is_nan(input logic [63:0] x);
    return (&x[62:52]) && (|x[51:0]);
  endfunction

  // Same priority as the result decode below, evaluated on the live inputs at accept
  assign special_in_d = Invalid || is_nan(A) || (!op_type && is_nan(B)) || (Ztype != 3'b000);

  always_comb begin
    sp_res_d = QNAN;
    sp_flg_d = '0;
    sx_d     = a_q[63] ^ b_q[63];
    if (inv_q) begin
      sp_flg_d = 5'b10000;
    end else if (is_nan(a_q) || (!op_q && is_nan(b_q))) begin
      sp_res_d = QNAN;
    end else if (z_q[2]) begin
      sp_res_d = {sx_d, 11'h7FF, 52'h0};
      sp_flg_d = 5'b01000;
    end else if (z_q == 3'b011) begin
      sp_res_d = {(op_q ? a_q[63] : sx_d), 63'h0};
    end else if (z_q == 3'b010) begin
      sp_res_d = {(op_q ? 1'b0 : sx_d), 11'h7FF, 52'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      z_q     <= '0;
      inv_q   <= 1'b0;
      den_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dps_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      dps_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op_type;
            z_q     <= Ztype;
            inv_q   <= Invalid;
            den_q   <= Denorm;
            busy_q  <= 1'b1;
            dps_q   <= !special_in_d;
            state_q <= special_in_d ? S_SPECIAL : S_RUN;
          end
        end
        S_SPECIAL: begin
          res_q   <= sp_res_d;
          flg_q   <= sp_flg_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_RUN: begin
          // counter is loaded while dp_start is high, so it expires LAT cycles after the launch cycle
          if (dps_q) begin
            cnt_q <= CW'(LAT - 1);
          end else if (cnt_q == '0) begin
            res_q   <= dp_result;
            flg_q   <= dp_flags;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dp_start    = dps_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign flags       = flg_q;
  assign denorm_flag = den_q;

`ifdef FDIV_STICKY_FLAGS_EN
  logic [4:0] sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else if (done_q) begin
      sticky_q <= clr_flags ? flg_q : (sticky_q | flg_q);
    end else if (clr_flags) begin
      sticky_q <= '0;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_flags;
  assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fpdivsqrt_seq.sv
// Self-checking bench for fpdivsqrt_seq: spec-level outcome model plus directed vectors
// with hand-computed literal results. Honours FDIV_STICKY_FLAGS_EN if defined.
module tb_fpdivsqrt_seq;

  localparam int unsigned LAT = 5;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, op_type = 1'b0;
  logic        Invalid = 1'b0, Denorm = 1'b0, clr_flags = 1'b0;
  logic [63:0] A = '0, B = '0, dp_result = '0;
  logic [2:0]  Ztype = '0;
  logic [4:0]  dp_flags = '0;
  logic        dp_start, busy, done, denorm_flag;
  logic [63:0] result;
  logic [4:0]  flags, sticky_flags;

  fpdivsqrt_seq #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_type(op_type), .A(A), .B(B),
    .Ztype(Ztype), .Invalid(Invalid), .Denorm(Denorm), .dp_start(dp_start),
    .dp_result(dp_result), .dp_flags(dp_flags), .busy(busy), .done(done),
    .result(result), .flags(flags), .denorm_flag(denorm_flag),
    .clr_flags(clr_flags), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic chk_en = 1'b0;
  logic [63:0] dpv = '0;
  logic [4:0]  dpf = '0;

  // Model state: what the unit must be doing, derived from accepted requests
  logic        m_active = 1'b0, m_normal = 1'b0, m_den = 1'b0;
  int          m_acc = 0, m_doneat = 0, m_valid_from = 0;
  logic [63:0] m_res = '0;
  logic [4:0]  m_flags = '0, m_sticky = '0;

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic nan64(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'h0);
  endfunction

  function automatic void outcome(input logic op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] z, input logic inv, input logic [63:0] dv,
                                  input logic [4:0] df, output logic [63:0] r,
                                  output logic [4:0] f, output logic sp);
    logic s;
    s  = a[63] ^ b[63];
    sp = 1'b1;
    f  = 5'b00000;
    r  = QNAN;
    if (inv) f = 5'b10000;
    else if (nan64(a) || (!op && nan64(b))) r = QNAN;
    else if (z[2]) begin r = {s, 11'h7FF, 52'h0}; f = 5'b01000; end
    else if (z == 3'b011) r = {(op ? a[63] : s), 63'h0};
    else if (z == 3'b010) r = {(op ? 1'b0 : s), 11'h7FF, 52'h0};
    else if (z == 3'b001) r = QNAN;
    else begin sp = 1'b0; r = dv; f = df; end
  endfunction

  function automatic logic exp_busy(input int c);
    return m_active && (c > m_acc) && (c <= m_doneat);
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] r;
    logic [4:0]  f;
    logic        sp;
    int          L;
    cyc <= cyc + 1;
    if (reset) begin
      m_active <= 1'b0; m_normal <= 1'b0; m_den <= 1'b0;
      m_res <= '0; m_flags <= '0; m_sticky <= '0; m_valid_from <= 0;
    end else begin
      if (m_active && cyc == m_doneat) m_sticky <= clr_flags ? m_flags : (m_sticky | m_flags);
      else if (clr_flags) m_sticky <= '0;
      if (start && !exp_busy(cyc)) begin
        outcome(op_type, A, B, Ztype, Invalid, dpv, dpf, r, f, sp);
        L = sp ? 2 : int'(LAT) + 2;
        m_active <= 1'b1; m_normal <= !sp; m_acc <= cyc; m_doneat <= cyc + L;
        m_res <= r; m_flags <= f; m_den <= Denorm; m_valid_from <= cyc + L;
      end
    end
  end

  // Datapath stand-in: correct value only in the cycle the result must be sampled
  always @(negedge clk) begin
    if (m_active && m_normal && cyc == m_acc + 1 + int'(LAT)) begin
      dp_result = dpv; dp_flags = dpf;
    end else begin
      dp_result = ~dpv; dp_flags = ~dpf;
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] exp_st;
    if (chk_en) begin
`ifdef FDIV_STICKY_FLAGS_EN
      exp_st = m_sticky;
`else
      exp_st = 5'b00000;
`endif
      chkb("done", done, m_active && cyc == m_doneat);
      chkb("busy", busy, exp_busy(cyc));
      chkb("dp_start", dp_start, m_active && m_normal && cyc == m_acc + 1);
      chkv("sticky", {59'b0, sticky_flags}, {59'b0, exp_st});
      if (cyc >= m_valid_from) begin
        chkv("result", result, m_res);
        chkv("flags", {59'b0, flags}, {59'b0, m_flags});
        chkb("denorm", denorm_flag, m_den);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < int'(LAT) + 8) begin tick; n++; end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s_timeout cyc=%0d got=no_done exp=done", nm, cyc);
    end
  endtask

  task automatic run_op(input string nm, input logic op, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] z, input logic inv, input logic den,
                        input logic [63:0] dv, input logic [4:0] df,
                        input logic [63:0] lres, input logic [4:0] lfl, input int lat,
                        input logic coinc_clr);
    int c0;
    op_type = op; A = a; B = b; Ztype = z; Invalid = inv; Denorm = den;
    dpv = dv; dpf = df; start = 1'b1; c0 = cyc;
    tick;
    start = 1'b0;
    wait_done(nm);
    if (done === 1'b1) begin
      chkv({nm, "_lat"}, 64'(cyc - c0), 64'(lat));
      chkv({nm, "_res"}, result, lres);
      chkv({nm, "_flg"}, {59'b0, flags}, {59'b0, lfl});
      if (coinc_clr) clr_flags = 1'b1;
    end
    tick;
    clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    tick;
    chk_en = 1'b1;
    tick; tick;
    reset = 1'b0;
    chkb("rst_busy", busy, 1'b0);
    chkv("rst_res", result, 64'h0);
    tick;

    run_op("div6_2", 1'b0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b000, 1'b0, 1'b0,
           64'h4008_0000_0000_0000, 5'b00000, 64'h4008_0000_0000_0000, 5'b00000, LAT + 2, 1'b0);
    run_op("divz", 1'b0, 64'h3FF0_0000_0000_0000, 64'h0, 3'b110, 1'b0, 1'b0,
           64'h1, 5'b0, 64'h7FF0_0000_0000_0000, 5'b01000, 2, 1'b0);
    run_op("sqrtneg", 1'b1, 64'hC010_0000_0000_0000, 64'h0, 3'b001, 1'b1, 1'b0,
           64'h1, 5'b0, QNAN, 5'b10000, 2, 1'b0);
    run_op("nzdivinf", 1'b0, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 3'b011, 1'b0, 1'b0,
           64'h1, 5'b0, 64'h8000_0000_0000_0000, 5'b00000, 2, 1'b0);
    run_op("sqrtnz", 1'b1, 64'h8000_0000_0000_0000, 64'h0, 3'b011, 1'b0, 1'b0,
           64'h1, 5'b0, 64'h8000_0000_0000_0000, 5'b00000, 2, 1'b0);
    run_op("nanb", 1'b0, 64'h3FF0_0000_0000_0000, 64'h7FF4_0000_0000_0000, 3'b000, 1'b0, 1'b0,
           64'h1, 5'b0, QNAN, 5'b00000, 2, 1'b0);
    run_op("sqrtinf", 1'b1, 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 3'b010, 1'b0, 1'b0,
           64'h1, 5'b0, 64'h7FF0_0000_0000_0000, 5'b00000, 2, 1'b0);
    run_op("ninfdiv", 1'b0, 64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b010, 1'b0, 1'b0,
           64'h1, 5'b0, 64'hFFF0_0000_0000_0000, 5'b00000, 2, 1'b0);

    // Starts during RUN and on the done cycle must be dropped
    op_type = 1'b0; A = 64'h4024_0000_0000_0000; B = 64'h4000_0000_0000_0000;
    Ztype = 3'b000; Invalid = 1'b0; Denorm = 1'b0;
    dpv = 64'h4014_0000_0000_0000; dpf = 5'b00000; start = 1'b1;
    tick;
    Ztype = 3'b011; A = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 3; i++) tick;
    start = 1'b0; Ztype = 3'b000;
    wait_done("ignore");
    chkv("ignore_res", result, 64'h4014_0000_0000_0000);
    Ztype = 3'b110; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chkb("ignore_idle", busy, 1'b0);

    // Reset while in RUN abandons the op
    Ztype = 3'b000; A = 64'h4024_0000_0000_0000; dpv = 64'h4014_0000_0000_0000; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chkb("rstrun_busy", busy, 1'b0);
    chkv("rstrun_res", result, 64'h0);
    for (int i = 0; i < int'(LAT) + 4; i++) tick;

    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    run_op("nx_den", 1'b0, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'b000, 1'b0, 1'b1,
           64'h3FD5_5555_5555_5555, 5'b00001, 64'h3FD5_5555_5555_5555, 5'b00001, LAT + 2, 1'b0);
    chkb("nx_den_flag", denorm_flag, 1'b1);
    run_op("dz2", 1'b0, 64'hBFF0_0000_0000_0000, 64'h0, 3'b110, 1'b0, 1'b0,
           64'h1, 5'b0, 64'hFFF0_0000_0000_0000, 5'b01000, 2, 1'b0);
`ifdef FDIV_STICKY_FLAGS_EN
    chkv("sticky_acc", {59'b0, sticky_flags}, 64'h09);
`else
    chkv("sticky_acc", {59'b0, sticky_flags}, 64'h00);
`endif
    run_op("nx_clr", 1'b0, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'b000, 1'b0, 1'b0,
           64'h3FD5_5555_5555_5555, 5'b00001, 64'h3FD5_5555_5555_5555, 5'b00001, LAT + 2, 1'b1);
`ifdef FDIV_STICKY_FLAGS_EN
    chkv("sticky_clr", {59'b0, sticky_flags}, 64'h01);
`else
    chkv("sticky_clr", {59'b0, sticky_flags}, 64'h00);
`endif
    tick; tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
